cache_miss_handler: RTL and testbench

CACHE_MISS_HANDLER -- requirements
Module: cache_miss_handler

---
 rtl/cache_miss_handler_pkg.sv | 32 +++
 rtl/cache_miss_handler_line_word_counter.sv | 48 ++++
 rtl/cache_miss_handler.sv | 197 +++++++++++++++++++
 tb/tb_cache_miss_handler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_miss_handler_pkg.sv
// ============================================================================
// Module   : cache_miss_handler_pkg
// Purpose  : Shared cache definitions: miss FSM states, geometry defaults,
//            and word/byte address helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_miss_handler_pkg;

  localparam int DEFAULT_SET_SIZE   = 4;
  localparam int DEFAULT_LINE_WORDS = 8;

  typedef enum logic [1:0] {
    MISS_IDLE   = 2'd0,
    MISS_WB     = 2'd1,
    MISS_FILL   = 2'd2,
    MISS_COMMIT = 2'd3
  } miss_state_e;

  // Shift that turns a word index into a byte offset.
  function automatic int word_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int word_idx_width(input int line_words);
    return $clog2(line_words);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_miss_handler_line_word_counter.sv
// ============================================================================
// Module   : line_word_counter
// Purpose  : Word index within a cache line; flags the ack that wraps it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_word_counter
  import cache_miss_handler_pkg::*;
#(
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clr_i,
  input  logic                          inc_i,
  output logic [$clog2(LINE_WORDS)-1:0] cnt_o,
  output logic                          wrap_o
);

  localparam int                CNT_W = word_idx_width(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LINE_WORDS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wrap_o = inc_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cache_miss_handler.sv
// ============================================================================
// Module   : cache_miss_handler
// Purpose  : Line refill engine with optional victim write-back, enabled by
//            the CACHE_WRITEBACK_EN macro (write-through build otherwise).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_miss_handler
  import cache_miss_handler_pkg::*;
#(
  parameter int SET_SIZE   = DEFAULT_SET_SIZE,
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          miss_req_i,
  input  logic [ADDR_WIDTH-1:0]         miss_addr_i,
  input  logic [SET_SIZE-1:0]           victim_line_i,
  input  logic                          victim_dirty_i,
  input  logic [ADDR_WIDTH-1:0]         victim_addr_i,
  input  logic [DATA_WIDTH-1:0]         victim_data_i,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  input  logic                          mem_ack_i,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
  output logic [SET_SIZE-1:0]           line_we_o,
  output logic [$clog2(LINE_WORDS)-1:0] line_word_o,
  output logic [DATA_WIDTH-1:0]         line_wdata_o,
  output logic [SET_SIZE-1:0]           line_commit_o,
  output logic                          busy_o,
  output logic                          miss_done_o
);

  localparam int CNT_W      = word_idx_width(LINE_WORDS);
  localparam int WORD_SHIFT = word_shift(DATA_WIDTH);

  miss_state_e           state_q, state_d;
  logic [SET_SIZE-1:0]   way_q, way_d;
  logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
  logic [SET_SIZE-1:0]   way_sel;
  logic                  found;
  logic [CNT_W-1:0]      cnt;
  logic                  wrap;
  logic                  cnt_clr;
  logic                  cnt_inc;
  logic [ADDR_WIDTH-1:0] byte_off;

`ifdef CACHE_WRITEBACK_EN
  logic [ADDR_WIDTH-1:0] victim_addr_q, victim_addr_d;
`else
  logic unused_victim;
  assign unused_victim = ^{victim_dirty_i, victim_addr_i, victim_data_i};
`endif

  line_word_counter #(
    .LINE_WORDS (LINE_WORDS)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (cnt),
    .wrap_o (wrap)
  );

  assign byte_off = ADDR_WIDTH'(cnt) << WORD_SHIFT;
  assign cnt_inc  = mem_ack_i && (state_q == MISS_WB || state_q == MISS_FILL);
  assign cnt_clr  = (state_q == MISS_IDLE) && miss_req_i;

  // Lowest set bit wins; an empty victim vector falls back to way 0.
  always_comb begin
    way_sel = '0;
    found   = 1'b0;
    for (int i = 0; i < SET_SIZE; i++) begin
      if (victim_line_i[i] && !found) begin
        way_sel[i] = 1'b1;
        found      = 1'b1;
      end
    end
    if (!found) begin
      way_sel[0] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    way_d       = way_q;
    miss_addr_d = miss_addr_q;
`ifdef CACHE_WRITEBACK_EN
    victim_addr_d = victim_addr_q;
`endif
    case (state_q)
      MISS_IDLE: begin
        if (miss_req_i) begin
          way_d       = way_sel;
          miss_addr_d = miss_addr_i;
`ifdef CACHE_WRITEBACK_EN
          victim_addr_d = victim_addr_i;
          state_d       = victim_dirty_i ? MISS_WB : MISS_FILL;
`else
          state_d       = MISS_FILL;
`endif
        end
      end
`ifdef CACHE_WRITEBACK_EN
      MISS_WB: begin
        if (wrap) begin
          state_d = MISS_FILL;
        end
      end
`endif
      MISS_FILL: begin
        if (wrap) begin
          state_d = MISS_COMMIT;
        end
      end
      MISS_COMMIT: begin
        state_d = MISS_IDLE;
      end
      default: begin
        state_d = MISS_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    line_we_o     = '0;
    line_word_o   = '0;
    line_wdata_o  = '0;
    line_commit_o = '0;
    busy_o        = 1'b0;
    miss_done_o   = 1'b0;
    case (state_q)
`ifdef CACHE_WRITEBACK_EN
      MISS_WB: begin
        busy_o      = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = victim_addr_q + byte_off;
        mem_wdata_o = victim_data_i;
        line_word_o = cnt;
      end
`endif
      MISS_FILL: begin
        busy_o      = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = miss_addr_q + byte_off;
        line_word_o = cnt;
        if (mem_ack_i) begin
          line_we_o    = way_q;
          line_wdata_o = mem_rdata_i;
        end
      end
      MISS_COMMIT: begin
        busy_o        = 1'b1;
        line_commit_o = way_q;
        miss_done_o   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= MISS_IDLE;
      way_q       <= '0;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      way_q       <= way_d;
      miss_addr_q <= miss_addr_d;
    end
  end

`ifdef CACHE_WRITEBACK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      victim_addr_q <= '0;
    end else begin
      victim_addr_q <= victim_addr_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_miss_handler.sv
// ============================================================================
// Module   : tb_cache_miss_handler
// Purpose  : Self-checking bench for cache_miss_handler (both build variants).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_miss_handler;

`ifdef CACHE_WRITEBACK_EN
  localparam bit WB_BUILD = 1'b1;
`else
  localparam bit WB_BUILD = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        miss_req_i = 1'b0;
  logic [31:0] miss_addr_i = '0;
  logic [3:0]  victim_line_i = '0;
  logic        victim_dirty_i = 1'b0;
  logic [31:0] victim_addr_i = '0;
  logic [31:0] victim_data_i = '0;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [3:0]  line_we_o;
  logic [2:0]  line_word_o;
  logic [31:0] line_wdata_o;
  logic [3:0]  line_commit_o;
  logic        busy_o;
  logic        miss_done_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          dirty;
    logic [3:0]  vline;
    logic [31:0] vaddr;
    logic [31:0] maddr;
    int          period;
    logic [3:0]  way;
    int          done_cyc;
  } vec_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  word;
  } xfer_t;

  vec_t vecs[5];

  cache_miss_handler dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .miss_req_i     (miss_req_i),
    .miss_addr_i    (miss_addr_i),
    .victim_line_i  (victim_line_i),
    .victim_dirty_i (victim_dirty_i),
    .victim_addr_i  (victim_addr_i),
    .victim_data_i  (victim_data_i),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i),
    .line_we_o      (line_we_o),
    .line_word_o    (line_word_o),
    .line_wdata_o   (line_wdata_o),
    .line_commit_o  (line_commit_o),
    .busy_o         (busy_o),
    .miss_done_o    (miss_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, ".outs"},
        {32'(mem_req_o), 32'(mem_we_o), 32'(line_we_o), 32'(line_commit_o),
         32'(busy_o), 32'(miss_done_o)} == '0 ? 64'd0 : 64'd1, 64'd0);
    chk({nm, ".addr"}, {32'd0, mem_addr_o}, 64'd0);
  endtask

  // Memory/victim side: victim data and read data are functions of the bus
  // the DUT presents, so the expected values below are fixed constants.
  task automatic drive_responses();
    #1;
    victim_data_i = 32'hD000_0000 | 32'(line_word_o);
    mem_rdata_i   = {16'hA5A5, mem_addr_o[15:0]};
    #1;
  endtask

  task automatic run_miss(input vec_t v, input string nm);
    xfer_t q[$];
    xfer_t e;
    int    c;
    bit    done;
    q = {};
    if (WB_BUILD && v.dirty) begin
      for (int k = 0; k < 8; k++) begin
        q.push_back('{1'b1, v.vaddr + 32'(4 * k), 32'hD000_0000 | 32'(k), 3'(k)});
      end
    end
    for (int k = 0; k < 8; k++) begin
      e.we   = 1'b0;
      e.addr = v.maddr + 32'(4 * k);
      e.data = {16'hA5A5, e.addr[15:0]};
      e.word = 3'(k);
      q.push_back(e);
    end
    @(negedge clk_i);
    miss_req_i     = 1'b1;
    victim_line_i  = v.vline;
    victim_dirty_i = v.dirty;
    victim_addr_i  = v.vaddr;
    miss_addr_i    = v.maddr;
    c    = 0;
    done = 1'b0;
    while (!done && c < 300) begin
      if (c > 0) @(negedge clk_i);
      if (c == 1) begin
        victim_line_i  = ~v.vline;
        victim_dirty_i = ~v.dirty;
        victim_addr_i  = 32'hDEAD_0000;
        miss_addr_i    = 32'hBEEF_0000;
      end
      mem_ack_i = ((c % v.period) == v.period - 1);
      drive_responses();
      if (c == 0) chk({nm, ".busy_at_accept"}, 64'(busy_o), 64'd0);
      if (mem_req_o) begin
        if (q.size() == 0) begin
          chk({nm, ".extra_xfer"}, 64'(mem_addr_o), 64'hFFFF_FFFF);
        end else begin
          e = q[0];
          chk({nm, ".mem_we"}, 64'(mem_we_o), 64'(e.we));
          chk({nm, ".mem_addr"}, 64'(mem_addr_o), 64'(e.addr));
          chk({nm, ".line_word"}, 64'(line_word_o), 64'(e.word));
          if (e.we) chk({nm, ".mem_wdata"}, 64'(mem_wdata_o), 64'(e.data));
          if (mem_ack_i) begin
            void'(q.pop_front());
            chk({nm, ".line_we"}, 64'(line_we_o), e.we ? 64'd0 : 64'(v.way));
            if (!e.we) chk({nm, ".line_wdata"}, 64'(line_wdata_o), 64'(e.data));
          end else begin
            chk({nm, ".line_we_noack"}, 64'(line_we_o), 64'd0);
          end
        end
      end else begin
        chk({nm, ".line_we_idle"}, 64'(line_we_o), 64'd0);
      end
      if (miss_done_o) begin
        done = 1'b1;
        chk({nm, ".commit"}, 64'(line_commit_o), 64'(v.way));
        chk({nm, ".left_xfers"}, 64'(q.size()), 64'd0);
        if (v.done_cyc > 0) chk({nm, ".done_cycle"}, 64'(c), 64'(v.done_cyc));
      end else begin
        chk({nm, ".commit_early"}, 64'(line_commit_o), 64'd0);
      end
      c++;
    end
    if (!done) chk({nm, ".timeout"}, 64'd0, 64'd1);
    @(negedge clk_i);
    miss_req_i = 1'b0;
    mem_ack_i  = 1'b0;
    #1;
    chk({nm, ".idle_after"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'b0100, 32'h0000_1000, 32'h0000_3000, 1, 4'b0100, 9};
    vecs[1] = '{1'b1, 4'b0001, 32'h0000_1000, 32'h0000_2000, 1, 4'b0001, WB_BUILD ? 17 : 9};
    vecs[2] = '{1'b0, 4'b1010, 32'h0000_4000, 32'h0000_5000, 3, 4'b0010, 0};
    vecs[3] = '{1'b0, 4'b0000, 32'h0000_6000, 32'h0000_7000, 1, 4'b0001, 9};
    vecs[4] = '{1'b1, 4'b1000, 32'h0000_8000, 32'h0000_9000, 2, 4'b1000, 0};

    #1;
    chk_idle_outputs("reset");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk_idle_outputs("post_reset");

    for (int i = 0; i < 5; i++) begin
      run_miss(vecs[i], $sformatf("vec%0d", i));
    end

    // Abort a clean fill after three acks with an asynchronous reset.
    @(negedge clk_i);
    miss_req_i     = 1'b1;
    victim_line_i  = 4'b0100;
    victim_dirty_i = 1'b0;
    miss_addr_i    = 32'h0000_A000;
    mem_ack_i      = 1'b1;
    drive_responses();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      drive_responses();
      chk($sformatf("abort.fill%0d_we", k), 64'(line_we_o), 64'(4'b0100));
    end
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk_idle_outputs("abort.in_reset");
    chk("abort.word", 64'(line_word_o), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      #1;
      chk("abort.no_commit", 64'(line_commit_o), 64'd0);
    end
    miss_req_i = 1'b0;
    mem_ack_i  = 1'b0;
    rst_ni     = 1'b1;
    @(negedge clk_i);
    #1;
    chk_idle_outputs("abort.released");
    run_miss(vecs[0], "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
